xnor_pattern_matcher: RTL and testbench
=======================================

Name: xnor_pattern_matcher

Overview:
- Parametrised, clocked successor to the 2-input XNOR equivalence cell.
- Shifts a serial bit stream into a WIDTH-bit window and compares it bit-by-bit against a programmable pattern, using XNOR equivalence with per-bit don't-care mask.
- Reports per-window similarity, a registered match pulse and a saturating match counter.
- Sits in the digital datapath behind the gate-primitive library; shares the DigitSupply rail convention.

Parameters:
- WIDTH, 8, window/pattern width in bits (>=2).
- COUNT_WIDTH, 8, width of saturating MatchCount.

Ports:
- Clock  input  1  sole clock, rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- DigitSupply  input  2  rail pair. [1] = logic-high rail, [0] = logic-low rail. Behaviour is defined only for 2'b10.
- LoadPattern  input  1  load PatternIn/MaskIn, restart fill.
- PatternIn  input  WIDTH  reference pattern.
- MaskIn  input  WIDTH  1 = don't-care bit.
- Enable  input  1  shift SerialIn into window this cycle.
- SerialIn  input  1  stream bit; enters window LSB, first bit ends at MSB.
- Primed  output  1  window holds WIDTH valid bits since last load/refill.
- Match  output  1  one-cycle pulse: primed window equals pattern on all unmasked bits.
- Similarity  output  $clog2(WIDTH+1)  count of unmasked bits equal to pattern.
- MatchCount  output  COUNT_WIDTH  saturating count of Match pulses since load.

Behaviour:
- Reset (ResetN low, asynchronous): window, pattern, mask, fill counter = 0; state IDLE; Primed = 0, Match = 0, Similarity = 0, MatchCount = 0. Release is synchronous to the next Clock edge.
- States: IDLE, FILL, ARMED.
  - IDLE: Enable ignored, window unchanged. LoadPattern -> FILL.
  - FILL: each Enable shifts window <= {window[WIDTH-2:0], SerialIn} and increments the fill counter. On the WIDTH-th shift, go to ARMED and set Primed = 1 on the same edge.
  - ARMED: each Enable shifts and evaluates the new window.
- LoadPattern in any state:
  - Captures pattern and mask, clears window, fill counter, MatchCount, Primed and Match; enters FILL.
  - LoadPattern has priority over a simultaneous Enable; SerialIn is dropped that cycle.
- Evaluation (Enable cycles only), computed from the post-shift window and registered on the same edge:
  - eq[i] = XNOR(window[i], pattern[i]).
  - Similarity = popcount(eq & ~mask).
  - Match = 1 when the post-shift state is ARMED (including the FILL->ARMED edge) and (eq | mask) is all ones.
  - Latency: Match/Similarity are visible in the cycle after the Enable cycle.
- Non-Enable cycles: Match = 0; Similarity holds its last value; window holds.
- Similarity also updates during FILL (partial window; zero-padded high bits compared normally). Match never asserts in FILL.
- All-ones mask: Similarity = 0; Match = 1 on every Enable in ARMED.
- MatchCount increments with each Match and saturates at 2^COUNT_WIDTH-1; no wrap.
- DigitSupply != 2'b10: outputs undefined (not checked).

Optional Feature:
- Macro XNOR_MATCH_NONOVERLAP_EN.
- Defined: after any Match, state returns to FILL and the fill counter clears; the window is kept, but Primed drops and WIDTH further Enables are required before the next Match. Matches are non-overlapping.
- Undefined: state stays ARMED and overlapping matches occur on consecutive Enables.

Test Plan:
1. ResetN low mid-FILL with Enable high -> same cycle: Primed = 0, Match = 0, Similarity = 0, MatchCount = 0. After release, Enable ignored until LoadPattern.
2. WIDTH=8, load PatternIn=8'hA5, MaskIn=8'h00; shift 1,0,1,0,0,1,0,1 on 8 consecutive Enables -> Primed = 1 after the 8th edge; next cycle Match = 1, Similarity = 8, MatchCount = 1; Match = 0 the cycle after.
3. PatternIn=8'hA0, MaskIn=8'h0F; shift 8'hAF MSB-first -> Match = 1, Similarity = 4. Then shift one 0 (window 8'h5E) -> Match = 0, Similarity = 0.
4. PatternIn=8'hFF, MaskIn=0; shift ten 1s -> macro off: Match on shifts 8, 9, 10, MatchCount = 3. Macro on: Match on shift 8 only, Primed drops, MatchCount = 1.
5. COUNT_WIDTH=2, PatternIn=8'h00, MaskIn=8'hFF; 12 Enables -> Match on Enables 8–12 (5 pulses); MatchCount = 3 and holds at 3.
6. LoadPattern and Enable high in the same cycle while ARMED -> SerialIn dropped; state FILL, Primed = 0, MatchCount = 0; 8 further Enables are required before Match can assert.

Source files
------------

// File: rtl/xnor_pattern_matcher.sv
// Serial-window XNOR pattern matcher with per-bit don't-care mask, similarity count
// and saturating match counter. Define XNOR_MATCH_NONOVERLAP_EN for non-overlapping matches.
module xnor_pattern_matcher #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                         Clock,
    input  logic                         ResetN,
    input  logic [1:0]                   DigitSupply,
    input  logic                         LoadPattern,
    input  logic [WIDTH-1:0]             PatternIn,
    input  logic [WIDTH-1:0]             MaskIn,
    input  logic                         Enable,
    input  logic                         SerialIn,
    output logic                         Primed,
    output logic                         Match,
    output logic [$clog2(WIDTH+1)-1:0]   Similarity,
    output logic [COUNT_WIDTH-1:0]       MatchCount
);
    localparam int SW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {IDLE, FILL, ARMED} state_e;

    state_e                 state_q, state_d;
    logic [SW-1:0]          fill_q, fill_d;
    logic [WIDTH-1:0]       win_q, win_d;
    logic [WIDTH-1:0]       pat_q, pat_d;
    logic [WIDTH-1:0]       mask_q, mask_d;
    logic                   primed_q, primed_d;
    logic                   match_q, match_d;
    logic [SW-1:0]          sim_q, sim_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                   supply_ok;
    logic [WIDTH-1:0]       win_shift, eq;
    logic [SW-1:0]          sim_v;
    logic                   armed_next;

    // Off-nominal rails leave behaviour undefined; freeze the block rather than act on it.
    assign supply_ok = (DigitSupply == 2'b10);
    assign win_shift = {win_q[WIDTH-2:0], SerialIn};
    assign eq        = ~(win_shift ^ pat_q);

    always_comb begin
        sim_v = '0;
        for (int i = 0; i < WIDTH; i++)
            sim_v = sim_v + SW'(eq[i] & ~mask_q[i]);
    end

    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        win_d      = win_q;
        pat_d      = pat_q;
        mask_d     = mask_q;
        primed_d   = primed_q;
        match_d    = 1'b0;
        sim_d      = sim_q;
        cnt_d      = cnt_q;
        armed_next = 1'b0;
        if (supply_ok && LoadPattern) begin
            state_d  = FILL;
            fill_d   = '0;
            win_d    = '0;
            pat_d    = PatternIn;
            mask_d   = MaskIn;
            primed_d = 1'b0;
            cnt_d    = '0;
        end else if (supply_ok && Enable && state_q != IDLE) begin
            win_d = win_shift;
            sim_d = sim_v;
            if (state_q == FILL) begin
                fill_d = fill_q + SW'(1);
                if (fill_q == SW'(WIDTH-1)) begin
                    state_d    = ARMED;
                    primed_d   = 1'b1;
                    armed_next = 1'b1;
                end
            end else begin
                armed_next = 1'b1;
            end
            match_d = armed_next && (&(eq | mask_q));
            if (match_d) begin
                if (cnt_q != '1)
                    cnt_d = cnt_q + COUNT_WIDTH'(1);
`ifdef XNOR_MATCH_NONOVERLAP_EN
                state_d  = FILL;
                fill_d   = '0;
                primed_d = 1'b0;
`else
`endif
            end
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q  <= IDLE;
            fill_q   <= '0;
            win_q    <= '0;
            pat_q    <= '0;
            mask_q   <= '0;
            primed_q <= 1'b0;
            match_q  <= 1'b0;
            sim_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            win_q    <= win_d;
            pat_q    <= pat_d;
            mask_q   <= mask_d;
            primed_q <= primed_d;
            match_q  <= match_d;
            sim_q    <= sim_d;
            cnt_q    <= cnt_d;
        end
    end

    assign Primed     = primed_q;
    assign Match      = match_q;
    assign Similarity = sim_q;
    assign MatchCount = cnt_q;
endmodule

// File: tb/tb_xnor_pattern_matcher.sv
// Directed-vector bench for xnor_pattern_matcher (WIDTH=8, COUNT_WIDTH=2 so saturation is reachable).
module tb_xnor_pattern_matcher;
    localparam int WIDTH = 8;
    localparam int CW    = 2;
`ifdef XNOR_MATCH_NONOVERLAP_EN
    localparam bit NONOV = 1'b1;
`else
    localparam bit NONOV = 1'b0;
`endif

    logic             Clock = 1'b0;
    logic             ResetN;
    logic [1:0]       DigitSupply;
    logic             LoadPattern;
    logic [WIDTH-1:0] PatternIn;
    logic [WIDTH-1:0] MaskIn;
    logic             Enable;
    logic             SerialIn;
    logic             Primed;
    logic             Match;
    logic [3:0]       Similarity;
    logic [CW-1:0]    MatchCount;

    int total = 0;
    int bad   = 0;

    xnor_pattern_matcher #(.WIDTH(WIDTH), .COUNT_WIDTH(CW)) dut (
        .Clock(Clock), .ResetN(ResetN), .DigitSupply(DigitSupply),
        .LoadPattern(LoadPattern), .PatternIn(PatternIn), .MaskIn(MaskIn),
        .Enable(Enable), .SerialIn(SerialIn), .Primed(Primed), .Match(Match),
        .Similarity(Similarity), .MatchCount(MatchCount)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic en, input logic sin, input logic ld);
        Enable = en; SerialIn = sin; LoadPattern = ld;
        @(posedge Clock); #1;
        Enable = 1'b0; LoadPattern = 1'b0;
    endtask

    task automatic load(input logic [WIDTH-1:0] pat, input logic [WIDTH-1:0] msk);
        PatternIn = pat; MaskIn = msk;
        tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic shift_bits(input logic [WIDTH-1:0] b, input int n);
        for (int i = WIDTH-1; i > WIDTH-1-n; i--) tick(1'b1, b[i], 1'b0);
    endtask

    initial begin
        ResetN = 1'b1; DigitSupply = 2'b10; LoadPattern = 1'b0;
        PatternIn = '0; MaskIn = '0; Enable = 1'b0; SerialIn = 1'b0;
        #1 ResetN = 1'b0;
        #11;
        chk("rst_primed", Primed, 0);
        chk("rst_match",  Match, 0);
        chk("rst_sim",    Similarity, 0);
        chk("rst_cnt",    MatchCount, 0);
        ResetN = 1'b1;
        @(posedge Clock); #1;

        // 1: reset mid-FILL with Enable high, then Enable ignored until load
        load(8'h00, 8'h00);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
        chk("t1_fill_sim", Similarity, 8);
        chk("t1_fill_primed", Primed, 0);
        Enable = 1'b1; SerialIn = 1'b1;
        #2 ResetN = 1'b0;
        #1;
        chk("t1_rst_primed", Primed, 0);
        chk("t1_rst_match",  Match, 0);
        chk("t1_rst_sim",    Similarity, 0);
        chk("t1_rst_cnt",    MatchCount, 0);
        @(posedge Clock); #1;
        ResetN = 1'b1;
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0);
        chk("t1_idle_primed", Primed, 0);
        chk("t1_idle_match",  Match, 0);
        chk("t1_idle_sim",    Similarity, 0);

        // 2: exact match on A5
        load(8'hA5, 8'h00);
        shift_bits(8'hA5, 7);
        chk("t2_pre_primed", Primed, 0);
        chk("t2_pre_match",  Match, 0);
        chk("t2_pre_sim",    Similarity, 1);
        tick(1'b1, 1'b1, 1'b0);
        chk("t2_primed", Primed, 1);
        chk("t2_match",  Match, 1);
        chk("t2_sim",    Similarity, 8);
        chk("t2_cnt",    MatchCount, 1);
        tick(1'b0, 1'b0, 1'b0);
        chk("t2_match_off", Match, 0);
        chk("t2_sim_hold",  Similarity, 8);
        chk("t2_cnt_hold",  MatchCount, 1);

        // 3: masked low nibble
        load(8'hA0, 8'h0F);
        shift_bits(8'hAF, 8);
        chk("t3_match", Match, 1);
        chk("t3_sim",   Similarity, 4);
        tick(1'b1, 1'b0, 1'b0);
        chk("t3_match2", Match, 0);
        chk("t3_sim2",   Similarity, 0);

        // 4: overlapping vs non-overlapping run of ones
        load(8'hFF, 8'h00);
        for (int s = 1; s <= 10; s++) begin
            tick(1'b1, 1'b1, 1'b0);
            if (s >= 7)
                chk($sformatf("t4_match_s%0d", s), Match, (s == 8 || (!NONOV && s > 8)) ? 1 : 0);
        end
        chk("t4_cnt",    MatchCount, NONOV ? 1 : 3);
        chk("t4_primed", Primed, NONOV ? 0 : 1);

        // 5: all-ones mask, counter saturation at 3
        load(8'h00, 8'hFF);
        for (int s = 1; s <= 12; s++) begin
            tick(1'b1, s[0], 1'b0);
            chk($sformatf("t5_match_e%0d", s), Match, (s == 8 || (!NONOV && s > 8)) ? 1 : 0);
            chk($sformatf("t5_sim_e%0d", s), Similarity, 0);
        end
        chk("t5_cnt", MatchCount, NONOV ? 1 : 3);
        tick(1'b0, 1'b0, 1'b0);
        chk("t5_cnt_hold", MatchCount, NONOV ? 1 : 3);

        // 6: load with simultaneous Enable while armed
        load(8'h00, 8'h00);
        shift_bits(8'hFF, 8);
        chk("t6_armed_primed", Primed, 1);
        chk("t6_armed_match",  Match, 0);
        PatternIn = 8'hFF; MaskIn = 8'h00;
        tick(1'b1, 1'b1, 1'b1);
        chk("t6_ld_primed", Primed, 0);
        chk("t6_ld_cnt",    MatchCount, 0);
        chk("t6_ld_match",  Match, 0);
        shift_bits(8'hFF, 7);
        chk("t6_7_match",  Match, 0);
        chk("t6_7_primed", Primed, 0);
        chk("t6_7_sim",    Similarity, 7);
        tick(1'b1, 1'b1, 1'b0);
        chk("t6_8_match",  Match, 1);
        chk("t6_8_primed", Primed, NONOV ? 0 : 1);
        chk("t6_8_cnt",    MatchCount, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
